line_gen: RTL and testbench
===========================

Name: line_gen

Overview:
- Bresenham line rasterizer. Accepts one line command (two endpoints plus a colour) over an rts/rtr handshake.
- Emits one pixel (x, y, colour) per transfer over an rts/rtr handshake.
- Sits directly upstream of the pixel fifo: out_* connects to the fifo in_* port, and fifo backpressure stalls the stepping.

Parameters:
- COORD_WIDTH, 10, bits per x/y coordinate (unsigned)
- COLOR_WIDTH, 12, bits of pixel colour (RGB444)
- SCREEN_W, 640, visible width; used only with LINE_GEN_CLIP_EN
- SCREEN_H, 480, visible height; used only with LINE_GEN_CLIP_EN

Ports:
- clk  in  1  clock
- rst_  in  1  reset, asynchronous, active-low
- in_x0, in_y0  in  COORD_WIDTH each  start point
- in_x1, in_y1  in  COORD_WIDTH each  end point
- in_color  in  COLOR_WIDTH  line colour
- in_rts  in  1  command source ready to send
- in_rtr  out  1  block ready to accept a command
- out_x, out_y  out  COORD_WIDTH each  current pixel
- out_color  out  COLOR_WIDTH  current pixel colour
- out_last  out  1  current pixel is the line endpoint
- out_rts  out  1  pixel valid
- out_rtr  in  1  consumer (fifo) ready
- done  out  1  one-cycle pulse when a line completes

Behaviour:
- Clock and reset: clk, with rst_ asynchronous, active-low.
- Reset: state=IDLE; all registers 0; in_rtr=1, out_rts=0, out_last=0, done=0, out_x/out_y/out_color=0.
- Transfers: in_xfc = in_rts & in_rtr; out_xfc = out_rts & out_rtr.
- States: IDLE, SETUP, DRAW.
- IDLE:
  - in_rtr=1 (combinational from state), out_rts=0.
  - On in_xfc: latch x0, y0, x1, y1, colour; go to SETUP.
- SETUP (1 cycle, in_rtr=0, out_rts=0):
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx = +1 if x1>=x0, else -1; sy likewise for y.
  - err = dx+dy.
  - cur_x=x0, cur_y=y0; go to DRAW.
- Arithmetic widths:
  - err, dx, dy are signed, COORD_WIDTH+3 bits.
  - e2 = 2*err at the same width.
  - cur_x/cur_y are COORD_WIDTH and never leave the endpoint bounding box, so they cannot wrap.
- DRAW:
  - out_rts=1; out_x=cur_x, out_y=cur_y, out_color=latched colour.
  - out_last = (cur_x==x1 && cur_y==y1).
- On out_xfc in DRAW:
  - If out_last: go to IDLE and pulse done for that one cycle.
  - Otherwise, both updates below are evaluated from the same e2 and both may apply in the same cycle:
    - if e2>=dy: err+=dy, cur_x+=sx
    - if e2<=dx: err+=dx, cur_y+=sy
- Stall: while out_rts=1 and out_rtr=0, every output and internal register holds.
- Latency and throughput:
  - in_xfc at cycle N gives the first out_rts at N+2.
  - One pixel per cycle while out_rtr=1.
  - An N-pixel line occupies N+2 cycles minimum.
  - in_rtr returns high the cycle after the final out_xfc. There is no command overlap.
- Degenerate lines:
  - x0==x1 && y0==y1: exactly one pixel with out_last=1.
  - Pixel count always = max(|dx|,|dy|)+1.
- Reset mid-line: immediate return to reset values; the partial line is discarded and nothing further is emitted.
- in_rts outside IDLE is ignored (in_rtr=0); the command is not consumed.

Optional Feature:
- Macro: LINE_GEN_CLIP_EN.
- When defined, pixels with cur_x>=SCREEN_W or cur_y>=SCREEN_H are not emitted:
  - out_rts=0 for that pixel.
  - The stepper advances one step per cycle internally, ignoring out_rtr.
  - If the endpoint is off-screen, the line ends when the endpoint step is reached: no out_last is produced, done still pulses, and the block returns to IDLE.
- When not defined, every pixel is emitted and SCREEN_W/SCREEN_H are unused.

Test Plan:
- Horizontal line: (0,0)->(3,0), colour 0xF00, out_rtr=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles starting 2 cycles after in_xfc; out_last only on (3,0); done pulses once.
- Single point: (5,5)->(5,5) -> exactly one pixel (5,5) with out_last=1; in_rtr high again the next cycle.
- Steep negative line: (2,5)->(0,0) -> sequence (2,5),(2,4),(1,3),(1,2),(0,1),(0,0); 6 pixels; out_last on (0,0).
- Backpressure: line (0,0)->(7,3), out_rtr low for 3 cycles after the 2nd pixel -> out_x/out_y/out_last frozen during the stall; full 8-pixel sequence identical to the unstalled run.
- Reset mid-line: assert rst_=0 during the 3rd pixel of (0,0)->(9,9) -> out_rts=0 and in_rtr=1 immediately; after release, a new command (1,1)->(2,1) yields exactly (1,1),(2,1).
- Clip (LINE_GEN_CLIP_EN, SCREEN_W=4): (2,0)->(6,0) -> only (2,0),(3,0) emitted, no out_last, done pulses, return to IDLE.

Source files
------------

// File: rtl/line_gen.sv
// Bresenham line rasterizer: one command in, one pixel per handshake out.
// Optional on-screen clipping is enabled by defining LINE_GEN_CLIP_EN.
module line_gen #(
    parameter int COORD_WIDTH = 10,
    parameter int COLOR_WIDTH = 12,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [COORD_WIDTH-1:0] in_x0,
    input  logic [COORD_WIDTH-1:0] in_y0,
    input  logic [COORD_WIDTH-1:0] in_x1,
    input  logic [COORD_WIDTH-1:0] in_y1,
    input  logic [COLOR_WIDTH-1:0] in_color,
    input  logic                   in_rts,
    output logic                   in_rtr,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic [COLOR_WIDTH-1:0] out_color,
    output logic                   out_last,
    output logic                   out_rts,
    input  logic                   out_rtr,
    output logic                   done
);

    localparam int EW = COORD_WIDTH + 3;

`ifdef LINE_GEN_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic [COORD_WIDTH:0] SW = SCREEN_W[COORD_WIDTH:0];
    localparam logic [COORD_WIDTH:0] SH = SCREEN_H[COORD_WIDTH:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [COORD_WIDTH-1:0] cur_x, cur_y, x1, y1;
    logic [COLOR_WIDTH-1:0] color;
    logic signed [EW-1:0]   dx, dy, err;
    logic                   sx_neg, sy_neg;

    logic [COORD_WIDTH-1:0] adx, ady;
    logic signed [EW-1:0]   dx_init, dy_init, e2, err_nxt;
    logic                   step_x, step_y;
    logic                   in_xfc, off, at_end, step;

    // Handshake, clipping and end-of-line decode from the current state.
    always_comb begin
        in_xfc   = in_rts & in_rtr;
        off      = CLIP_EN &&
                   (({1'b0, cur_x} >= SW) || ({1'b0, cur_y} >= SH));
        at_end   = (cur_x == x1) && (cur_y == y1);
        in_rtr   = (state == IDLE);
        out_rts  = (state == DRAW) && !off;
        out_last = (state == DRAW) && at_end && !off;
        step     = (state == DRAW) && (off || out_rtr);
        done     = step && at_end;
        out_x     = cur_x;
        out_y     = cur_y;
        out_color = color;
    end

    // Bresenham setup deltas and per-pixel error update.
    always_comb begin
        adx     = (x1 >= cur_x) ? (x1 - cur_x) : (cur_x - x1);
        ady     = (y1 >= cur_y) ? (y1 - cur_y) : (cur_y - y1);
        dx_init = signed'({3'b000, adx});
        dy_init = -signed'({3'b000, ady});
        e2      = err <<< 1;
        step_x  = (e2 >= dy);
        step_y  = (e2 <= dx);
        err_nxt = err;
        if (step_x) err_nxt = err_nxt + dy;
        if (step_y) err_nxt = err_nxt + dx;
    end

    // Next-state: accept command, one setup cycle, draw until the endpoint.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_xfc) state_nxt = SETUP;
            SETUP:   state_nxt = DRAW;
            DRAW:    if (step && at_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    // Datapath: latch command, initialise the stepper, then walk the line.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cur_x  <= '0;
            cur_y  <= '0;
            x1     <= '0;
            y1     <= '0;
            color  <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_xfc) begin
                        cur_x <= in_x0;
                        cur_y <= in_y0;
                        x1    <= in_x1;
                        y1    <= in_y1;
                        color <= in_color;
                    end
                end
                SETUP: begin
                    dx     <= dx_init;
                    dy     <= dy_init;
                    err    <= dx_init + dy_init;
                    sx_neg <= (x1 < cur_x);
                    sy_neg <= (y1 < cur_y);
                end
                DRAW: begin
                    if (step && !at_end) begin
                        err <= err_nxt;
                        if (step_x)
                            cur_x <= sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
                        if (step_y)
                            cur_y <= sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_gen.sv
// Directed bench for line_gen: reset, lines, stall, reset mid-line.
// Clip scenario runs only when LINE_GEN_CLIP_EN is defined.
module tb_line_gen;

    logic       clk = 1'b0;
    logic       rst_;
    logic [9:0] in_x0, in_y0, in_x1, in_y1;
    logic [11:0] in_color;
    logic       in_rts, in_rtr;
    logic [9:0] out_x, out_y;
    logic [11:0] out_color;
    logic       out_last, out_rts, out_rtr, done;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_base;

    line_gen #(
        .COORD_WIDTH(10),
        .COLOR_WIDTH(12),
        .SCREEN_W(4),
        .SCREEN_H(480)
    ) dut (
        .clk(clk),
        .rst_(rst_),
        .in_x0(in_x0),
        .in_y0(in_y0),
        .in_x1(in_x1),
        .in_y1(in_y1),
        .in_color(in_color),
        .in_rts(in_rts),
        .in_rtr(in_rtr),
        .out_x(out_x),
        .out_y(out_y),
        .out_color(out_color),
        .out_last(out_last),
        .out_rts(out_rts),
        .out_rtr(out_rtr),
        .done(done)
    );

    always #5 clk = ~clk;

    // Count done pulses mid-cycle, away from the active edge.
    always @(negedge clk) if (rst_ && done) done_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x0, input int y0, input int x1,
                        input int y1, input int c);
        in_x0 = 10'(x0);
        in_y0 = 10'(y0);
        in_x1 = 10'(x1);
        in_y1 = 10'(y1);
        in_color = 12'(c);
        in_rts = 1'b1;
        done_base = done_cnt;
        check("cmd_rtr", int'(in_rtr), 1);
        cyc();
        in_rts = 1'b0;
        check("setup_rts", int'(out_rts), 0);
        check("setup_rtr", int'(in_rtr), 0);
        cyc();
    endtask

    task automatic px(input int x, input int y, input int last, input int c);
        check("px_rts", int'(out_rts), 1);
        check("px_x", int'(out_x), x);
        check("px_y", int'(out_y), y);
        check("px_last", int'(out_last), last);
        check("px_color", int'(out_color), c);
        check("px_done", int'(done), last);
        cyc();
    endtask

    task automatic line_end();
        check("end_rtr", int'(in_rtr), 1);
        check("end_rts", int'(out_rts), 0);
        check("end_done_cnt", done_cnt - done_base, 1);
    endtask

    initial begin
        rst_ = 1'b0;
        in_x0 = '0; in_y0 = '0; in_x1 = '0; in_y1 = '0;
        in_color = '0;
        in_rts = 1'b0;
        out_rtr = 1'b1;
        #12;
        check("rst_in_rtr", int'(in_rtr), 1);
        check("rst_out_rts", int'(out_rts), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_color", int'(out_color), 0);
        rst_ = 1'b1;
        cyc();

        // Horizontal line
        send(0, 0, 3, 0, 12'hF00);
        px(0, 0, 0, 12'hF00);
        px(1, 0, 0, 12'hF00);
        px(2, 0, 0, 12'hF00);
        px(3, 0, 1, 12'hF00);
        line_end();

        // Single point
        send(5, 5, 5, 5, 12'h0F0);
        px(5, 5, 1, 12'h0F0);
        line_end();

        // Ignored command outside IDLE
        send(2, 5, 0, 0, 12'h00F);
        in_rts = 1'b1;
        in_x0 = 10'd9;
        check("busy_rtr", int'(in_rtr), 0);
        px(2, 5, 0, 12'h00F);
        in_rts = 1'b0;
        px(2, 4, 0, 12'h00F);
        px(1, 3, 0, 12'h00F);
        px(1, 2, 0, 12'h00F);
        px(0, 1, 0, 12'h00F);
        px(0, 0, 1, 12'h00F);
        line_end();

        // Backpressure on the 3rd pixel
        send(0, 0, 7, 3, 12'h123);
        px(0, 0, 0, 12'h123);
        px(1, 0, 0, 12'h123);
        out_rtr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_rts", int'(out_rts), 1);
            check("stall_x", int'(out_x), 2);
            check("stall_y", int'(out_y), 1);
            check("stall_last", int'(out_last), 0);
            check("stall_done", int'(done), 0);
            cyc();
        end
        out_rtr = 1'b1;
        px(2, 1, 0, 12'h123);
        px(3, 1, 0, 12'h123);
        px(4, 2, 0, 12'h123);
        px(5, 2, 0, 12'h123);
        px(6, 3, 0, 12'h123);
        px(7, 3, 1, 12'h123);
        line_end();

        // Reset during the 3rd pixel
        send(0, 0, 9, 9, 12'hABC);
        px(0, 0, 0, 12'hABC);
        px(1, 1, 0, 12'hABC);
        check("mid_x", int'(out_x), 2);
        rst_ = 1'b0;
        #1;
        check("mid_rst_rts", int'(out_rts), 0);
        check("mid_rst_rtr", int'(in_rtr), 1);
        check("mid_rst_x", int'(out_x), 0);
        cyc();
        #3;
        rst_ = 1'b1;
        cyc();
        check("post_rst_rts", int'(out_rts), 0);
        cyc();
        check("post_rst_rts2", int'(out_rts), 0);
        send(1, 1, 2, 1, 12'h777);
        px(1, 1, 0, 12'h777);
        px(2, 1, 1, 12'h777);
        line_end();

`ifdef LINE_GEN_CLIP_EN
        // Clip against SCREEN_W=4
        send(2, 0, 6, 0, 12'hFFF);
        px(2, 0, 0, 12'hFFF);
        px(3, 0, 0, 12'hFFF);
        out_rtr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("clip_rts", int'(out_rts), 0);
            check("clip_done", int'(done), 0);
            cyc();
        end
        check("clip_end_rts", int'(out_rts), 0);
        check("clip_end_last", int'(out_last), 0);
        check("clip_end_done", int'(done), 1);
        cyc();
        out_rtr = 1'b1;
        line_end();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
